// File: rtl/matrix_op_controller.sv
// Sequencer between two 5x5 signed-byte operand banks and an external matrix ALU.
// Optional WAIT timeout enabled by defining CTRL_TIMEOUT_EN.
module matrix_op_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int N_ELEM         = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [4:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [2:0]            size,
    input  logic [7:0]            scalar_in,
    input  logic [4:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  result_valid,
    output logic [7:0]            res_number,
    output logic                  res_overflow,
    output logic                  error,
    output logic [N_ELEM*8-1:0]   alu_A_flat,
    output logic [N_ELEM*8-1:0]   alu_B_flat,
    output logic [7:0]            alu_scalar,
    output logic [2:0]            alu_opcode,
    output logic [2:0]            alu_matrix_size,
    input  logic [N_ELEM*8-1:0]   alu_C_flat,
    input  logic [7:0]            alu_number,
    input  logic                  alu_overflow_flag,
    input  logic                  alu_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [N_ELEM*8-1:0] bank_a_r, bank_b_r, result_r;
    logic [2:0]          op_r, size_r, opcode_nxt_s;
    logic [7:0]          scalar_r, number_r, rd_data_r;
    logic                overflow_r, error_r, busy_r, valid_r;
    logic                busy_nxt_s, valid_nxt_s;
    logic                legal_s, accept_s, reject_s, wr_ok_s, timeout_hit_s;

    // Determinant needs a size the ALU supports; opcode 000 is never legal.
    function automatic logic op_legal(input logic [2:0] o, input logic [2:0] s);
        logic ok;
        ok = (o != 3'd0);
        if ((o == 3'd7) && ((s < 3'd2) || (s > 3'd5))) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign legal_s  = op_legal(op, size);
    assign accept_s = (state_r == ST_IDLE) && start && legal_s;
    assign reject_s = (state_r == ST_IDLE) && start && !legal_s;
    assign wr_ok_s  = wr_en && (state_r == ST_IDLE) && (32'(wr_addr) < N_ELEM);

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;

    assign timeout_hit_s = (state_r == ST_WAIT) && !alu_done &&
                           (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive WAIT cycles without alu_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !alu_done && !timeout_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = (alu_done || timeout_hit_s) ? ST_DONE : ST_WAIT;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flags are registered yet cycle-exact.
    always_comb begin
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        valid_nxt_s  = (state_nxt_s == ST_DONE);
        opcode_nxt_s = 3'd0;
        if (state_nxt_s == ST_ISSUE) begin
            opcode_nxt_s = op;
        end else if (state_nxt_s == ST_WAIT) begin
            opcode_nxt_s = op_r;
        end else begin
            opcode_nxt_s = 3'd0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            alu_opcode <= 3'd0;
        end else begin
            busy_r     <= busy_nxt_s;
            valid_r    <= valid_nxt_s;
            alu_opcode <= opcode_nxt_s;
        end
    end

    // Operand banks, latched request, error flag, result capture and readback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_a_r   <= '0;
            bank_b_r   <= '0;
            result_r   <= '0;
            op_r       <= 3'd0;
            size_r     <= 3'd0;
            scalar_r   <= 8'd0;
            number_r   <= 8'd0;
            overflow_r <= 1'b0;
            error_r    <= 1'b0;
            rd_data_r  <= 8'd0;
        end else begin
            if (wr_ok_s && !wr_sel) begin
                bank_a_r[{wr_addr, 3'b000} +: 8] <= wr_data;
            end
            if (wr_ok_s && wr_sel) begin
                bank_b_r[{wr_addr, 3'b000} +: 8] <= wr_data;
            end
            if (accept_s) begin
                op_r     <= op;
                size_r   <= size;
                scalar_r <= scalar_in;
            end
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (reject_s || timeout_hit_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
            // A timeout leaves the previous results in place.
            if ((state_r == ST_WAIT) && alu_done) begin
                result_r   <= alu_C_flat;
                number_r   <= alu_number;
                overflow_r <= alu_overflow_flag;
            end
            rd_data_r <= (32'(rd_addr) < N_ELEM) ? result_r[{rd_addr, 3'b000} +: 8] : 8'h00;
        end
    end

    assign alu_A_flat      = bank_a_r;
    assign alu_B_flat      = bank_b_r;
    assign alu_scalar      = scalar_r;
    assign alu_matrix_size = size_r;
    assign rd_data         = rd_data_r;
    assign busy            = busy_r;
    assign result_valid    = valid_r;
    assign res_number      = number_r;
    assign res_overflow    = overflow_r;
    assign error           = error_r;

endmodule

// File: tb/tb_matrix_op_controller.sv
// Self-checking bench for matrix_op_controller with a behavioural ALU model and result scoreboard.
module tb_matrix_op_controller;

    typedef struct packed {
        logic [199:0] c;
        logic [7:0]   num;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] size;
        logic [7:0] scal;
        int         exp_lat;
    } vec_t;

    logic         clock, reset, wr_en, wr_sel, start;
    logic [4:0]   wr_addr, rd_addr;
    logic [7:0]   wr_data, scalar_in, rd_data, res_number, alu_scalar, alu_number;
    logic [2:0]   op, size, alu_opcode, alu_matrix_size;
    logic         busy, result_valid, res_overflow, error, alu_overflow_flag, alu_done;
    logic [199:0] alu_A_flat, alu_B_flat, alu_C_flat;

    logic [199:0] sh_a, sh_b;
    res_t         sb[$];
    res_t         last_exp, tmp_exp;
    int           n_tests, n_fail, vcount, alu_cnt, lat, v0, bad;
    bit           hold_done;
    vec_t         tbl[7];

    matrix_op_controller dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .op(op), .size(size), .scalar_in(scalar_in),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .result_valid(result_valid),
        .res_number(res_number), .res_overflow(res_overflow), .error(error),
        .alu_A_flat(alu_A_flat), .alu_B_flat(alu_B_flat), .alu_scalar(alu_scalar),
        .alu_opcode(alu_opcode), .alu_matrix_size(alu_matrix_size), .alu_C_flat(alu_C_flat),
        .alu_number(alu_number), .alu_overflow_flag(alu_overflow_flag), .alu_done(alu_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic res_t alu_fn(input logic [199:0] a, input logic [199:0] b,
                                    input logic [2:0] o, input logic [7:0] sc, input logic [2:0] sz);
        res_t r;
        logic [7:0] x, y, z;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            x = a[k*8 +: 8];
            y = b[k*8 +: 8];
            case (o)
                3'd1: z = x + y;
                3'd2: z = x - y;
                3'd3: begin
                    z = 8'd0;
                    for (int i = 0; i < 5; i++) z = z + a[((k/5)*5+i)*8 +: 8] * b[(i*5+(k%5))*8 +: 8];
                end
                3'd4: z = -x;
                3'd5: z = a[(((k%5)*5)+(k/5))*8 +: 8];
                3'd6: z = x * sc;
                default: z = 8'd0;
            endcase
            r.c[k*8 +: 8] = z;
            if (o == 3'd1 && x[7] == y[7] && z[7] != x[7]) r.ovf = 1'b1;
        end
        if (o == 3'd7) r.num = (sz == 3'd2) ? (a[7:0] * a[55:48] - a[15:8] * a[47:40]) : (a[7:0] + 8'(sz));
        if (o == 3'd6) r.ovf = r.c[7];
        return r;
    endfunction

    // ALU model: answers one cycle after issue unless held off.
    always @(negedge clock) begin
        if (alu_opcode == 3'd0) begin
            alu_cnt  <= 0;
            alu_done <= 1'b0;
        end else begin
            alu_cnt  <= alu_cnt + 1;
            alu_done <= (alu_cnt >= 1) && !hold_done;
            {alu_C_flat, alu_number, alu_overflow_flag} <=
                alu_fn(alu_A_flat, alu_B_flat, alu_opcode, alu_scalar, alu_matrix_size);
        end
    end

    always @(negedge clock) if (result_valid === 1'b1) vcount <= vcount + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [4:0] addr, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) sh_b[addr*8 +: 8] = d;
        else     sh_a[addr*8 +: 8] = d;
    endtask

    task automatic do_start(input logic [2:0] o, input logic [2:0] s, input logic [7:0] sc);
        op = o; size = s; scalar_in = sc; start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (o != 3'd0 && !(o == 3'd7 && (s < 3'd2 || s > 3'd5)))
            sb.push_back(alu_fn(sh_a, sh_b, o, sc, s));
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (result_valid !== 1'b1 && l < 64) begin
            tick();
            l++;
        end
        if (result_valid !== 1'b1) chk("valid_timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic check_result();
        res_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            chk("res_number", 32'(res_number), 32'(e.num));
            chk("res_overflow", 32'(res_overflow), 32'(e.ovf));
            for (int k = 0; k < 25; k++) begin
                rd_addr = 5'(k);
                tick();
                if (k == 0) chk("valid_one_cycle", 32'(result_valid), 32'd0);
                chk($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(e.c[k*8 +: 8]));
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; vcount = 0; alu_cnt = 0; hold_done = 1'b0;
        alu_done = 1'b0; alu_C_flat = '0; alu_number = 8'd0; alu_overflow_flag = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'd0; start = 1'b0;
        op = 3'd0; size = 3'd0; scalar_in = 8'd0; rd_addr = 5'd0;
        sh_a = '0; sh_b = '0; last_exp = '0;
        tbl[0] = '{3'd1, 3'd0, 8'd0, 2};
        tbl[1] = '{3'd2, 3'd0, 8'd0, 2};
        tbl[2] = '{3'd3, 3'd0, 8'd0, 2};
        tbl[3] = '{3'd4, 3'd0, 8'd0, 2};
        tbl[4] = '{3'd5, 3'd0, 8'd0, 2};
        tbl[5] = '{3'd6, 3'd0, 8'd3, 2};
        tbl[6] = '{3'd7, 3'd5, 8'd0, 2};

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_bank_a", 32'(alu_A_flat[31:0]), 32'd0);

        // Directed add with latency and element checks.
        wr(1'b0, 5'd0, 8'hE4); wr(1'b1, 5'd0, 8'h00);
        wr(1'b0, 5'd3, 8'h03); wr(1'b1, 5'd3, 8'hCF);
        v0 = vcount;
        do_start(3'd1, 3'd0, 8'd0);
        chk("issue_opcode", 32'(alu_opcode), 32'd1);
        chk("issue_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        chk("add_latency", 32'(lat), 32'd2);
        check_result();
        rd_addr = 5'd0; tick(); chk("add_rd0", 32'(rd_data), 32'hE4);
        rd_addr = 5'd3; tick(); chk("add_rd3", 32'(rd_data), 32'hD2);
        rd_addr = 5'd25; tick(); chk("rd_oob25", 32'(rd_data), 32'h00);
        rd_addr = 5'd31; tick(); chk("rd_oob31", 32'(rd_data), 32'h00);
        chk("add_pulses", 32'(vcount - v0), 32'd1);

        // Table-driven operations on random operands.
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 25; k++) begin
                wr(1'b0, 5'(k), 8'($urandom_range(0, 255)));
                wr(1'b1, 5'(k), 8'($urandom_range(0, 255)));
            end
            do_start(tbl[t].op, tbl[t].size, tbl[t].scal);
            wait_valid(lat);
            chk($sformatf("tbl%0d_latency", t), 32'(lat), 32'(tbl[t].exp_lat));
            chk($sformatf("tbl%0d_error", t), 32'(error), 32'd0);
            check_result();
        end

        // Determinant size 2, then an illegal size.
        wr(1'b0, 5'd0, 8'd3); wr(1'b0, 5'd1, 8'd2);
        wr(1'b0, 5'd5, 8'd1); wr(1'b0, 5'd6, 8'd4);
        do_start(3'd7, 3'd2, 8'd0);
        chk("det_size", 32'(alu_matrix_size), 32'd2);
        chk("det_opcode", 32'(alu_opcode), 32'd7);
        wait_valid(lat);
        chk("det_value", 32'(res_number), 32'd10);
        check_result();
        do_start(3'd7, 3'd6, 8'd0);
        chk("det6_error", 32'(error), 32'd1);
        chk("det6_busy", 32'(busy), 32'd0);
        tick();
        chk("det6_busy_hold", 32'(busy), 32'd0);
        do_start(3'd0, 3'd0, 8'd0);
        chk("op0_busy", 32'(busy), 32'd0);

        // Same-edge write lands before issue; write during WAIT is dropped.
        hold_done = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h07;
        sh_a[7:0] = 8'h07;
        do_start(3'd1, 3'd0, 8'd0);
        chk("same_edge_wr", 32'(alu_A_flat[7:0]), 32'h07);
        chk("start_clears_err", 32'(error), 32'd0);
        tick();
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("wait_wr_ignored", 32'(alu_A_flat[7:0]), 32'h07);
        op = 3'd2; start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_busy", 32'(alu_opcode), 32'd1);
        hold_done = 1'b0;
        wait_valid(lat);
        check_result();

        // ALU never answers.
        hold_done = 1'b1;
        do_start(3'd2, 3'd0, 8'd0);
`ifdef CTRL_TIMEOUT_EN
        tmp_exp = sb.pop_back();
        sb.push_back(last_exp);
        wait_valid(lat);
        chk("timeout_latency", 32'(lat), 32'd17);
        chk("timeout_error", 32'(error), 32'd1);
        check_result();
        do_start(3'd1, 3'd0, 8'd0);
        tick();
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b1 || result_valid !== 1'b0) bad++;
        end
        chk("no_timeout_busy", 32'(bad), 32'd0);
`endif

        // Reset while waiting.
        chk("pre_reset_busy", 32'(busy), 32'd1);
        v0 = vcount;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_opcode", 32'(alu_opcode), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_number", 32'(res_number), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_bank_a", 32'(alu_A_flat[31:0]), 32'd0);
        chk("arst_bank_b", 32'(alu_B_flat[31:0]), 32'd0);
        tick();
        reset = 1'b0;
        hold_done = 1'b0;
        sb.delete(); sh_a = '0; sh_b = '0;
        repeat (5) tick();
        chk("arst_no_pulse", 32'(vcount - v0), 32'd0);
        wr(1'b0, 5'd0, 8'd1); wr(1'b1, 5'd0, 8'd2);
        do_start(3'd1, 3'd0, 8'd0);
        wait_valid(lat);
        chk("post_rst_latency", 32'(lat), 32'd2);
        check_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/matrix_op_controller.md
MATRIX_OP_CONTROLLER -- requirements
Module: matrix_op_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of WAIT cycles without alu_done before the operation aborts.
REQ-002 SHALL have parameter N_ELEM, default 25: elements per 5x5 operand bank.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 wr_en  in  1  operand element write strobe.
REQ-006 wr_sel  in  1  target bank: 0 = A, 1 = B.
REQ-007 wr_addr  in  5  element index r*5+c, range 0..24.
REQ-008 wr_data  in  8  signed element value.
REQ-009 start  in  1  request one ALU operation.
REQ-010 op  in  3  ALU opcode: 001 add, 010 sub, 011 mul, 100 negate, 101 transpose, 110 scalar, 111 determinant.
REQ-011 size  in  3  matrix size for determinant, range 2..5.
REQ-012 scalar_in  in  8  scalar operand.
REQ-013 rd_addr  in  5  result element index.
REQ-014 rd_data  out  8  registered result element.
REQ-015 busy  out  1  operation in progress.
REQ-016 result_valid  out  1  one-cycle completion pulse.
REQ-017 res_number  out  8  captured determinant.
REQ-018 res_overflow  out  1  captured ALU overflow.
REQ-019 error  out  1  sticky error flag.
REQ-020 ALU-side ports: alu_A_flat out 200, alu_B_flat out 200, alu_scalar out 8, alu_opcode out 3, alu_matrix_size out 3, alu_C_flat in 200, alu_number in 8, alu_overflow_flag in 1, alu_done in 1.

Function
REQ-021 Element k SHALL occupy bits [k*8+7:k*8] of the A, B, and result banks; alu_A_flat and alu_B_flat SHALL drive the banks directly.
REQ-022 A write with wr_en=1 SHALL update the selected bank at the edge only in IDLE with wr_addr<=24; otherwise the write SHALL be ignored.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT, and DONE; busy SHALL be 1 in ISSUE, WAIT, and DONE.
REQ-024 In IDLE with start=1 and a legal op, the FSM SHALL latch op, size, and scalar_in, clear error, and move to ISSUE; a write on the same edge SHALL land before the ALU is issued.
REQ-025 op=000, or op=111 with size outside 2..5, SHALL be rejected: the FSM stays in IDLE and error=1 from the next cycle.
REQ-026 alu_opcode SHALL carry the latched op in ISSUE and WAIT and 000 otherwise; alu_scalar and alu_matrix_size SHALL hold their latched values.
REQ-027 ISSUE SHALL move to WAIT unconditionally after one cycle.
REQ-028 In WAIT, alu_done=1 at an edge SHALL capture alu_C_flat, alu_number, and alu_overflow_flag into the result registers and move to DONE.
REQ-029 DONE SHALL last exactly one cycle with result_valid=1, then move to IDLE.
REQ-030 Minimum latency SHALL be: start accepted at edge N, result_valid high in the cycle after edge N+2.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 rd_data SHALL equal result element rd_addr one cycle after rd_addr is sampled; rd_addr>24 SHALL return 0x00.
REQ-033 The result registers SHALL hold their values until the next successful capture.

Reset
REQ-034 reset=1 SHALL asynchronously force: state IDLE, both operand banks and all result registers 0, alu_opcode 000, busy 0, result_valid 0, error 0, rd_data 0x00, timeout counter 0.
REQ-035 reset asserted mid-operation SHALL abandon the operation with no result_valid pulse.

Configuration
REQ-036 With CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT; TIMEOUT_CYCLES WAIT cycles without alu_done SHALL move to DONE with error=1, a result_valid pulse, and results left unchanged.
REQ-037 Without CTRL_TIMEOUT_EN, WAIT SHALL persist until alu_done or reset, and no counter logic SHALL exist.

Verification
REQ-038 Add: write A[0]=0xE4, B[0]=0x00, A[3]=0x03, B[3]=0xCF, start op=001, ALU model with done one cycle after issue -> result_valid pulses once; rd_addr=0 gives 0xE4; rd_addr=3 gives 0xD2.
REQ-039 Determinant: op=111 with size=2 -> alu_matrix_size=2 and res_number matches the model; op=111 with size=6 -> error=1 and busy stays 0.
REQ-040 start and wr_en(A[0]=0x07) on the same IDLE edge -> alu_A_flat[7:0]=0x07 at ISSUE; a write attempted during WAIT leaves the bank unchanged.
REQ-041 Model holds alu_done=0 -> with CTRL_TIMEOUT_EN: DONE after 16 WAIT cycles, error=1, result unchanged; without it: busy stays 1 through 100 cycles.
REQ-042 reset pulsed in WAIT -> all outputs 0 immediately; no result_valid pulse; next start accepted normally.
